// File: rtl/axi_lite_master_read.sv
// AXI4-Lite read initiator: accepts one user read request at a time, runs the AR/R
// handshakes, returns data/response to the user, and flags slow bus transactions.
module axi_lite_master_read #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  M_AXIL_ACLK,
    input  logic                  M_AXIL_ARESET,
    output logic                  M_AXIL_ARVALID,
    input  logic                  M_AXIL_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_AXIL_ARADDR,
    output logic [2:0]            M_AXIL_ARPROT,
    input  logic                  M_AXIL_RVALID,
    output logic                  M_AXIL_RREADY,
    input  logic [DATA_WIDTH-1:0] M_AXIL_RDATA,
    input  logic [1:0]            M_AXIL_RRESP,
    input  logic                  user_port_arvalid,
    output logic                  user_port_arready,
    input  logic [ADDR_WIDTH-1:0] user_port_araddr,
    input  logic [2:0]            user_port_arprot,
    output logic                  user_port_rvalid,
    input  logic                  user_port_rready,
    output logic [DATA_WIDTH-1:0] user_port_rdata,
    output logic [1:0]            user_port_rresp,
    output logic                  timeout_flag
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic [2:0]            arprot_q,  arprot_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q,  rready_d;
    logic                  urvalid_q, urvalid_d;
    logic [DATA_WIDTH-1:0] urdata_q,  urdata_d;
    logic [1:0]            urresp_q,  urresp_d;
    logic                  tflag_q,   tflag_d;
    logic [15:0]           wd_cnt_q,  wd_cnt_d;
    logic                  wd_busy_s;
    logic                  wd_hit_s;

    // Next-state, datapath and watchdog logic
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arprot_d  = arprot_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        urvalid_d = urvalid_q;
        urdata_d  = urdata_q;
        urresp_d  = urresp_q;
        tflag_d   = tflag_q;
        wd_cnt_d  = wd_cnt_q;
        wd_busy_s = (state_q == S_ADDR) || (state_q == S_DATA);
        wd_hit_s  = WD_EN && ({16'd0, wd_cnt_q} == WD_LAST);

        if (wd_busy_s && (wd_cnt_q != 16'hFFFF)) begin
            wd_cnt_d = wd_cnt_q + 16'd1;
        end else begin
            wd_cnt_d = wd_cnt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (user_port_arvalid) begin
                    araddr_d  = user_port_araddr;
                    arprot_d  = user_port_arprot;
                    tflag_d   = 1'b0;
                    wd_cnt_d  = 16'd0;
                    arvalid_d = 1'b1;
                    state_d   = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                // Leaving ADDR only moves the wait to DATA, so a hit here always counts
                if (wd_hit_s) begin
                    tflag_d = 1'b1;
                end else begin
                    tflag_d = tflag_q;
                end
                if (M_AXIL_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (M_AXIL_RVALID) begin
                    urdata_d  = M_AXIL_RDATA;
                    urresp_d  = M_AXIL_RRESP;
                    rready_d  = 1'b0;
                    urvalid_d = 1'b1;
                    state_d   = S_RESP;
                end else if (wd_hit_s) begin
                    tflag_d = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                if (user_port_rready) begin
                    urvalid_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                urvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge M_AXIL_ACLK) begin
        if (M_AXIL_ARESET) begin
            state_q   <= S_IDLE;
            araddr_q  <= '0;
            arprot_q  <= 3'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            urvalid_q <= 1'b0;
            urdata_q  <= '0;
            urresp_q  <= 2'd0;
            tflag_q   <= 1'b0;
            wd_cnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arprot_q  <= arprot_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            urvalid_q <= urvalid_d;
            urdata_q  <= urdata_d;
            urresp_q  <= urresp_d;
            tflag_q   <= tflag_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    assign M_AXIL_ARVALID    = arvalid_q;
    assign M_AXIL_ARADDR     = araddr_q;
    assign M_AXIL_ARPROT     = arprot_q;
    assign M_AXIL_RREADY     = rready_q;
    assign user_port_rvalid  = urvalid_q;
    assign user_port_rdata   = urdata_q;
    assign user_port_rresp   = urresp_q;
    assign timeout_flag      = tflag_q;
    assign user_port_arready = (state_q == S_IDLE);

endmodule

// File: tb/tb_axi_lite_master_read.sv
// Self-checking bench for axi_lite_master_read: directed test-plan cases plus randomized
// transactions, checked against a transaction-level model of handshakes and the watchdog.
module tb_axi_lite_master_read;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          areset;
    logic          m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0] m_araddr;
    logic [2:0]    m_arprot;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          u_arvalid, u_arready, u_rvalid, u_rready;
    logic [AW-1:0] u_araddr;
    logic [2:0]    u_arprot;
    logic [DW-1:0] u_rdata;
    logic [1:0]    u_rresp;
    logic          t_flag;

    always #5 clk = ~clk;

    axi_lite_master_read #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXIL_ACLK      (clk),
        .M_AXIL_ARESET    (areset),
        .M_AXIL_ARVALID   (m_arvalid),
        .M_AXIL_ARREADY   (m_arready),
        .M_AXIL_ARADDR    (m_araddr),
        .M_AXIL_ARPROT    (m_arprot),
        .M_AXIL_RVALID    (m_rvalid),
        .M_AXIL_RREADY    (m_rready),
        .M_AXIL_RDATA     (m_rdata),
        .M_AXIL_RRESP     (m_rresp),
        .user_port_arvalid(u_arvalid),
        .user_port_arready(u_arready),
        .user_port_araddr (u_araddr),
        .user_port_arprot (u_arprot),
        .user_port_rvalid (u_rvalid),
        .user_port_rready (u_rready),
        .user_port_rdata  (u_rdata),
        .user_port_rresp  (u_rresp),
        .timeout_flag     (t_flag)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    int     ar_hs    = 0;
    int     r_hs     = 0;
    int     exp_ar   = 0;
    int     exp_r    = 0;
    longint cyc      = 0;
    longint last_acc = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus handshake counter and cycle counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!areset && m_arvalid && m_arready) ar_hs <= ar_hs + 1;
        if (!areset && m_rvalid && m_rready)   r_hs  <= r_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ctl"}, {m_arvalid, m_rready, u_rvalid, t_flag, u_arready}, 5'b00001);
        check_val({tag, "_addr"}, {29'd0, m_arprot, m_araddr}, 64'd0);
        check_val({tag, "_data"}, {30'd0, u_rresp, u_rdata}, 64'd0);
    endtask

    // One full read: stalls in cycles, watchdog flag expected once edges in ADDR/DATA reach TO
    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot,
                           input logic [31:0] data, input logic [1:0] resp,
                           input int ar_dly, input int r_dly, input int u_dly,
                           input logic hold_next, input int exp_gap);
        int     n;
        int     w;
        logic   exp_flag;
        longint acc;
        w = 0;
        while (!u_arready && w < 50) begin
            tick();
            w++;
        end
        check_val("arready_idle", u_arready, 1);
        u_arvalid = 1'b1;
        u_araddr  = addr;
        u_arprot  = prot;
        tick();
        acc = cyc;
        if (exp_gap > 0) check_val("accept_gap", acc - last_acc, exp_gap);
        last_acc = acc;
        if (hold_next) begin
            u_araddr = ~addr;
            u_arprot = ~prot;
        end else begin
            u_arvalid = 1'b0;
        end
        exp_ar++;
        check_val("ar_issue", {m_arvalid, u_arready, t_flag, m_arprot, m_araddr}, {1'b1, 1'b0, 1'b0, prot, addr});
        n = 0;
        for (int i = 0; i < ar_dly; i++) begin
            m_arready = 1'b0;
            m_rvalid  = 1'($urandom_range(0, 1));
            m_rdata   = $urandom;
            tick();
            n++;
            check_val("ar_stall", {m_arvalid, m_rready, m_arprot, m_araddr}, {1'b1, 1'b0, prot, addr});
            check_val("wd_addr", t_flag, (n >= TO));
        end
        m_arready = 1'b1;
        m_rvalid  = 1'b0;
        tick();
        n++;
        m_arready = 1'b0;
        check_val("ar_done", {m_arvalid, m_rready}, 2'b01);
        check_val("wd_ar_done", t_flag, (n >= TO));
        for (int i = 0; i < r_dly; i++) begin
            tick();
            n++;
            check_val("r_stall", {m_rready, u_rvalid}, 2'b10);
            check_val("wd_data", t_flag, (n >= TO));
        end
        m_rvalid = 1'b1;
        m_rdata  = data;
        m_rresp  = resp;
        tick();
        n++;
        m_rvalid = 1'b0;
        m_rdata  = $urandom;
        m_rresp  = 2'($urandom_range(0, 3));
        exp_r++;
        exp_flag = (n > TO);
        check_val("r_done", {m_rready, u_rvalid}, 2'b01);
        check_val("rdata", {u_rresp, u_rdata}, {resp, data});
        check_val("wd_final", t_flag, exp_flag);
        for (int i = 0; i < u_dly; i++) begin
            tick();
            check_val("resp_hold", {u_rvalid, u_rresp, u_rdata}, {1'b1, resp, data});
            check_val("wd_hold", t_flag, exp_flag);
        end
        u_rready = 1'b1;
        tick();
        u_rready = 1'b0;
        check_val("resp_done", {u_rvalid, u_arready, t_flag}, {1'b0, 1'b1, exp_flag});
        check_val("hs_counts", {ar_hs, r_hs}, {exp_ar, exp_r});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        areset    = 1'b1;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = 32'd0;
        m_rresp   = 2'd0;
        u_arvalid = 1'b0;
        u_araddr  = 32'd0;
        u_arprot  = 3'd0;
        u_rready  = 1'b0;
        repeat (3) tick();
        areset = 1'b0;
        check_idle_outputs("reset");

        // Zero-wait read
        do_read(32'h0000_0010, 3'd0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 1'b0, 0);
        // Backpressure on all three handshakes
        do_read(32'h0000_0020, 3'd5, 32'hCAFE_F00D, 2'b01, 3, 5, 2, 1'b0, 0);
        // Error response passed through, no retry
        do_read(32'h0000_0030, 3'd2, 32'h1234_5678, 2'b10, 1, 1, 0, 1'b0, 0);
        do_read(32'h0000_0034, 3'd1, 32'h0BAD_0BAD, 2'b11, 0, 2, 1, 1'b0, 0);
        // Watchdog: slave silent well past the limit, then the late beat completes
        do_read(32'h0000_0040, 3'd0, 32'hA5A5_5A5A, 2'b00, 0, 12, 0, 1'b0, 0);
        // Watchdog boundary: completion on the limit edge wins, one edge later sets
        do_read(32'h0000_0044, 3'd0, 32'h0000_0044, 2'b00, 0, TO - 2, 0, 1'b0, 0);
        do_read(32'h0000_0048, 3'd0, 32'h0000_0048, 2'b00, 0, TO - 1, 0, 1'b0, 0);
        do_read(32'h0000_004C, 3'd0, 32'h0000_004C, 2'b00, TO + 2, 0, 0, 1'b0, 0);

        // Reset in the middle of DATA
        u_arvalid = 1'b1;
        u_araddr  = 32'h0000_0100;
        u_arprot  = 3'd3;
        tick();
        u_arvalid = 1'b0;
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        exp_ar++;
        tick();
        check_val("pre_rst_rready", m_rready, 1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_idle_outputs("mid_rst");
        do_read(32'h0000_0004, 3'd0, 32'h4444_0004, 2'b00, 0, 1, 0, 1'b0, 0);

        // Back-to-back with user_port_arvalid held high
        do_read(32'h0000_0200, 3'd0, 32'h0000_0001, 2'b00, 0, 0, 0, 1'b1, 0);
        do_read(32'h0000_0204, 3'd0, 32'h0000_0002, 2'b00, 0, 0, 0, 1'b1, 4);
        do_read(32'h0000_0208, 3'd0, 32'h0000_0003, 2'b00, 0, 0, 0, 1'b0, 4);

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            do_read($urandom, 3'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)),
                    $urandom_range(0, 4), $urandom_range(0, 9), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 0);
        end
        u_arvalid = 1'b0;
        tick();
        tick();
        check_val("final_counts", {ar_hs, r_hs}, {exp_ar, exp_r});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
